// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one 32x32 multiplier core between two requesters.
// Sequences the core's init/ready handshake and aborts hung operations with a watchdog.
module mult_arbiter #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic        req1,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic [1:0]  grant,
  output logic [1:0]  done,
  output logic        err,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic [31:0] m_a,
  output logic [31:0] m_b,
  output logic        m_init,
  input  logic        m_ready,
  input  logic [31:0] m_res_up,
  input  logic [31:0] m_res_dn
);

  // Core handshake: m_init is a level held for the whole operation; the core
  // answers with m_ready (plus result words) while m_init stays high.
  typedef enum logic [1:0] {IDLE, LOAD, RUN, GAP} state_t;

  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_n;
  logic             last, last_n;
  logic [CNT_W-1:0] wdog, wdog_n;
  logic [1:0]       grant_n, done_n;
  logic             err_n, m_init_n;
  logic [31:0]      res_hi_n, res_lo_n, m_a_n, m_b_n;
  logic             sel;

  always_comb begin
    state_n  = state;
    last_n   = last;
    wdog_n   = wdog;
    grant_n  = grant;
    done_n   = done;
    err_n    = err;
    m_init_n = m_init;
    res_hi_n = res_hi;
    res_lo_n = res_lo;
    m_a_n    = m_a;
    m_b_n    = m_b;
    // On a tie, the requester that was not served last time wins.
    sel      = (req0 && req1) ? ~last : req1;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant_n = sel ? 2'b10 : 2'b01;
          m_a_n   = sel ? a1 : a0;
          m_b_n   = sel ? b1 : b0;
          state_n = LOAD;
        end
      end
      LOAD: begin
        m_init_n = 1'b1;
        wdog_n   = '0;
        state_n  = RUN;
      end
      RUN: begin
        wdog_n = wdog + CNT_W'(1);
        if (m_ready) begin
          res_hi_n = m_res_up;
          res_lo_n = m_res_dn;
          err_n    = 1'b0;
          done_n   = grant;
          m_init_n = 1'b0;
          state_n  = GAP;
        end else if (wdog == WDOG_LAST) begin
          res_hi_n = '0;
          res_lo_n = '0;
          err_n    = 1'b1;
          done_n   = grant;
          m_init_n = 1'b0;
          state_n  = GAP;
        end
      end
      GAP: begin
        done_n  = 2'b00;
        grant_n = 2'b00;
        last_n  = grant[1];
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      last   <= 1'b1;
      wdog   <= '0;
      grant  <= 2'b00;
      done   <= 2'b00;
      err    <= 1'b0;
      m_init <= 1'b0;
      res_hi <= '0;
      res_lo <= '0;
      m_a    <= '0;
      m_b    <= '0;
    end else begin
      state  <= state_n;
      last   <= last_n;
      wdog   <= wdog_n;
      grant  <= grant_n;
      done   <= done_n;
      err    <= err_n;
      m_init <= m_init_n;
      res_hi <= res_hi_n;
      res_lo <= res_lo_n;
      m_a    <= m_a_n;
      m_b    <= m_b_n;
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter: a behavioural multiplier core with per-operation
// latency, a round-robin reference model feeding exp_q, and a monitor checking every done.
module tb_mult_arbiter;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 5;
  localparam int W       = 77;   // {done, grant, err, product[63:0], m_init high cycles[7:0]}
  localparam int HANG    = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [1:0]  grant, done;
  logic        err, m_init;
  logic [31:0] res_hi, res_lo, m_a, m_b;
  logic        m_ready = 1'b0;
  logic [31:0] m_res_up = '0, m_res_dn = '0;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[$];
  int           delay_q[$];
  logic [31:0]  op_a[2][4], op_b[2][4];
  int           op_d[2][4];
  int           m_last = 1;
  bit           stale = 1'b0;

  mult_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .grant(grant), .done(done), .err(err),
    .res_hi(res_hi), .res_lo(res_lo),
    .m_a(m_a), .m_b(m_b), .m_init(m_init),
    .m_ready(m_ready), .m_res_up(m_res_up), .m_res_dn(m_res_dn)
  );

  always #5 clk = ~clk;

  // Multiplier core: answers op_d cycles after m_init rises; optional stale ready while idle-granted.
  int cur_d = 0, cnt = 0;
  bit armed = 1'b0;
  always @(negedge clk) begin
    if (!m_init) begin
      armed    = 1'b0;
      cnt      = 0;
      m_ready  = stale && (grant != 2'b00);
      m_res_up = 32'hDEAD_BEEF;
      m_res_dn = 32'hBAAD_F00D;
    end else begin
      if (!armed) begin
        armed = 1'b1;
        cnt   = 0;
        if (delay_q.size() > 0) cur_d = delay_q.pop_front();
        else cur_d = HANG;
      end
      cnt++;
      if (cnt >= cur_d) begin
        m_ready = 1'b1;
        {m_res_up, m_res_dn} = {32'b0, m_a} * {32'b0, m_b};
      end else begin
        m_ready  = 1'b0;
        m_res_up = $urandom;
        m_res_dn = $urandom;
      end
    end
  end

  // Monitor: counts m_init-high cycles and checks each completion against exp_q.
  logic [7:0] run_cnt = '0;
  always begin
    logic [W-1:0] act, expv;
    @(posedge clk);
    #1;
    if (rst) run_cnt = '0;
    else if (m_init) run_cnt = run_cnt + 8'd1;
    if (done != 2'b00) begin
      act = {done, grant, err, res_hi, res_lo, run_cnt};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: got %0h with nothing expected", act);
      end else begin
        expv = exp_q.pop_front();
        if (act !== expv) begin
          n_err++;
          $display("FAIL completion: got %0h expected %0h", act, expv);
        end
      end
      run_cnt = '0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic fill_random();
    for (int s = 0; s < 2; s++)
      for (int j = 0; j < 4; j++) begin
        op_a[s][j] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
        op_b[s][j] = $urandom;
        op_d[s][j] = ($urandom_range(0, 7) == 0) ? HANG : $urandom_range(1, TIMEOUT + 2);
      end
  endtask

  // Both requesters raise together and hold req until their last operation is done.
  task automatic run_scenario(input int n0, input int n1);
    int rem[2];
    int k[2];
    int s, d, budget;
    logic [63:0] prod;
    logic [1:0] who, pg;
    rem[0] = n0; rem[1] = n1;
    k[0] = 0; k[1] = 0;
    while (rem[0] + rem[1] > 0) begin
      if (rem[0] > 0 && rem[1] > 0) s = 1 - m_last;
      else s = (rem[0] > 0) ? 0 : 1;
      m_last = s;
      d   = op_d[s][k[s]];
      who = (s == 1) ? 2'b10 : 2'b01;
      prod = {32'b0, op_a[s][k[s]]} * {32'b0, op_b[s][k[s]]};
      if (d <= TIMEOUT) exp_q.push_back({who, who, 1'b0, prod, 8'(d)});
      else exp_q.push_back({who, who, 1'b1, 64'b0, 8'(TIMEOUT)});
      delay_q.push_back(d);
      k[s]++;
      rem[s]--;
    end
    rem[0] = n0; rem[1] = n1;
    k[0] = 0; k[1] = 0;
    a0 = op_a[0][0]; b0 = op_b[0][0];
    a1 = op_a[1][0]; b1 = op_b[1][0];
    req0 = (n0 > 0);
    req1 = (n1 > 0);
    budget = 40 * (n0 + n1) + 20;
    pg = grant;
    while (rem[0] + rem[1] > 0 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
      if (grant != 2'b00 && pg == 2'b00) begin
        if (grant[0]) begin a0 = $urandom; b0 = $urandom; end
        else begin a1 = $urandom; b1 = $urandom; end
      end
      pg = grant;
      if (done[0]) begin
        rem[0]--; k[0]++;
        if (rem[0] > 0) begin a0 = op_a[0][k[0]]; b0 = op_b[0][k[0]]; end
        else req0 = 1'b0;
      end
      if (done[1]) begin
        rem[1]--; k[1]++;
        if (rem[1] > 0) begin a1 = op_a[1][k[1]]; b1 = op_b[1][k[1]]; end
        else req1 = 1'b0;
      end
    end
    if (rem[0] + rem[1] > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scenario_timeout: got %0d ops outstanding expected 0", rem[0] + rem[1]);
      req0 = 1'b0;
      req1 = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int n0, n1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_res_hi", 64'(res_hi), 64'd0);
    check("rst_res_lo", 64'(res_lo), 64'd0);
    check("rst_m_a", 64'(m_a), 64'd0);
    check("rst_m_b", 64'(m_b), 64'd0);
    check("rst_m_init", 64'(m_init), 64'd0);

    // 7*6 on requester 0 with 5-cycle core, then tie alternation 01,10,01
    fill_random();
    op_a[0][0] = 32'd7; op_b[0][0] = 32'd6; op_d[0][0] = 5;
    run_scenario(2, 1);

    // all-ones operands on requester 1
    fill_random();
    op_a[1][0] = 32'hFFFF_FFFF; op_b[1][0] = 32'hFFFF_FFFF; op_d[1][0] = 3;
    run_scenario(0, 1);

    // hung core then a normal operation
    fill_random();
    op_d[0][0] = HANG; op_d[0][1] = 4;
    run_scenario(2, 0);

    // stale ready during LOAD, ready coincident with watchdog expiry
    fill_random();
    stale = 1'b1;
    op_d[0][0] = TIMEOUT; op_d[1][0] = 2;
    run_scenario(1, 1);
    stale = 1'b0;

    // reset while RUN: no completion, then requester 0 wins the tie
    a0 = $urandom; b0 = $urandom;
    delay_q.push_back(HANG);
    req0 = 1'b1;
    for (int i = 0; i < 10 && !m_init; i++) begin
      @(posedge clk);
      #1;
    end
    check("mid_run_m_init_up", 64'(m_init), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    req0 = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_m_init", 64'(m_init), 64'd0);
    check("mid_rst_grant", 64'(grant), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    m_last = 1;
    delay_q.delete();
    repeat (4) @(posedge clk);
    #1;
    fill_random();
    run_scenario(1, 1);

    for (int t = 0; t < 25; t++) begin
      fill_random();
      stale = ($urandom_range(0, 3) == 0);
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range(0, 3);
      if (n0 + n1 == 0) n0 = 1;
      run_scenario(n0, n1);
    end
    stale = 1'b0;

    repeat (5) @(posedge clk);
    #1;
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
